uart_rx_core: RTL and testbench

Serial receive front end for the MP3 player's phone-control path. Oversamples the asynchronous `UART_RX` line at 16× baud, validates start/stop framing, votes each bit from three mid-bit samples, and delivers each byte on `RXD_DATA` with a one-cycle `uart_state` strobe. It sits directly upstream of the Bluetooth command decoder. That decoder reads `RXD_DATA` as a level, so the last good byte must stay stable until the next good byte arrives.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx_core.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART receive path (and a future transmitter):
//   - rx_state_t   : receiver FSM state encoding (3-bit)
//   - calc_div     : clocks per 16x oversample tick from clock and baud rate
//   - counter_width: width of the oversample divider counter
//   - majority3    : 2-of-3 vote used to resolve each bit
//   - phase constants for the three mid-bit samples
//
// No ports; this is a package.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Mid-bit sample points within the 16 oversample phases of a bit.
    // The bit is resolved when the last of the three samples is taken.
    localparam logic [3:0] PH_EARLY = 4'd7;
    localparam logic [3:0] PH_MID   = 4'd8;
    localparam logic [3:0] PH_LATE  = 4'd9;

    localparam logic [2:0] LAST_BIT_IDX = 3'd7;

    // Integer truncation is intentional: the residual baud error is small
    // compared with the tolerance the mid-bit sampling gives.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * 16);
    endfunction

    function automatic int counter_width(input int div);
        return $clog2(div);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//
// Oversample tick generator. Counts 0..DIV-1 and pulses tick for one clock
// on DIV-1. While restart is high the counter is held at 0 and no tick is
// produced, so the first tick after restart drops comes exactly DIV clocks
// later.
//
// Ports:
//   clk     in  1 : system clock, rising edge
//   rst_n   in  1 : asynchronous active-low reset
//   restart in  1 : hold the counter at 0 (no ticks)
//   tick    out 1 : one-cycle pulse every DIV clocks
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV   = 651,
    parameter int CNT_W = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !restart && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// 8N1 UART receiver with 16x oversampling and three-sample majority voting.
// A good frame updates RXD_DATA and pulses uart_state; a frame whose stop
// bit votes low pulses frame_err, leaves RXD_DATA untouched and waits for
// the line to return high before looking for the next start bit.
// RXD_DATA is consumed as a level downstream, so it only changes on a good
// frame (or reset).
//
// Ports:
//   CLK        in  1 : system clock, rising edge
//   RST        in  1 : asynchronous active-low reset
//   UART_RX    in  1 : asynchronous serial input, idles high
//   RXD_DATA   out 8 : last correctly framed byte
//   uart_state out 1 : one-cycle pulse, RXD_DATA updated
//   frame_err  out 1 : one-cycle pulse, stop bit low, byte dropped
//   busy       out 1 : receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DIV      = calc_div(CLK_FREQ, BAUD)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RX,
    output logic [7:0] RXD_DATA,
    output logic       uart_state,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = counter_width(DIV);

    logic       rx_meta;
    logic       rx_s;
    rx_state_t  state;
    rx_state_t  state_nx;
    logic       tick;
    logic [3:0] ph;
    logic       samp_early;
    logic       samp_mid;
    logic       resolve;
    logic       vote;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       shift_en;
    logic       load_byte;
    logic       flag_err;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    // Divider is parked while idle so the start-bit timing is anchored to
    // the cycle the falling edge was seen.
    uart_baud_tick #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_baud_tick (
        .clk     (CLK),
        .rst_n   (RST),
        .restart (state == ST_IDLE),
        .tick    (tick)
    );

    // Phase within the current bit. It wraps 15->0 naturally, which marks
    // each bit boundary without any explicit bookkeeping.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ph <= '0;
        end else if (state == ST_IDLE) begin
            ph <= '0;
        end else if (tick) begin
            ph <= ph + 4'd1;
        end
    end

    // Capture the first two mid-bit samples; the third is taken live from
    // rx_s at the resolve tick.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_early <= 1'b0;
            samp_mid   <= 1'b0;
        end else if (tick) begin
            if (ph == PH_EARLY) begin
                samp_early <= rx_s;
            end
            if (ph == PH_MID) begin
                samp_mid <= rx_s;
            end
        end
    end

    assign resolve = tick && (ph == PH_LATE);
    assign vote    = majority3(samp_early, samp_mid, rx_s);
    assign busy    = (state != ST_IDLE);

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the one-cycle control strobes that drive the
    // datapath and output registers below.
    always_comb begin
        state_nx  = state;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        flag_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (resolve) begin
                    state_nx = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (resolve) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT_IDX) begin
                        state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (resolve) begin
                    if (vote) begin
                        load_byte = 1'b1;
                        state_nx  = ST_IDLE;
                    end else begin
                        flag_err  = 1'b1;
                        state_nx  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Shift register and bit index. Bits land LSB first at their own index,
    // so the register never needs clearing between frames: all eight
    // positions are rewritten before a byte can be delivered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (state == ST_START) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            shreg[bit_idx] <= vote;
            bit_idx        <= bit_idx + 3'd1;
        end
    end

    // Output registers. The strobes come from mutually exclusive FSM
    // branches, so uart_state and frame_err can never coincide.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RXD_DATA   <= 8'h00;
            uart_state <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            uart_state <= load_byte;
            frame_err  <= flag_err;
            if (load_byte) begin
                RXD_DATA <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
//
// Drives serial frames into uart_rx_core and scoreboards every uart_state /
// frame_err strobe against expectations pushed when each frame is sent.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CLK  = 160;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rxLine = 1'b1;
    logic [7:0] rxdData;
    logic       uartState;
    logic       frameErr;
    logic       busy;

    typedef struct packed {
        logic       isErr;
        logic [7:0] data;
    } expEvent_t;

    expEvent_t  expQ[$];
    expEvent_t  monEv;
    logic [7:0] modelLast = 8'h00;
    int         nVectors = 0;
    int         nMiscompares = 0;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .CLK        (clk),
        .RST        (rstN),
        .UART_RX    (rxLine),
        .RXD_DATA   (rxdData),
        .uart_state (uartState),
        .frame_err  (frameErr),
        .busy       (busy)
    );

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reset with immediate check of all outputs; the model forgets any
    // frame in flight and its last delivered byte.
    task automatic doReset();
        rstN = 1'b0;
        expQ.delete();
        modelLast = 8'h00;
        #1;
        checkOutput("reset_rxd_data", {24'h0, rxdData}, 32'h0);
        checkOutput("reset_uart_state", {31'h0, uartState}, 32'h0);
        checkOutput("reset_frame_err", {31'h0, frameErr}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        rxLine = 1'b1;
        repeat (5) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Sends one 8N1 frame with bitClk clocks per bit. A good stop bit
    // expects the byte; a low stop bit expects a framing error. The line is
    // left at the stop-bit level. spikeBit inverts one clock mid-bit;
    // abortBit resets the DUT partway through that bit (nothing expected).
    task automatic applyStimulus(input logic [7:0] data, input logic stopVal,
                                 input int bitClk, input int spikeBit, input int abortBit);
        logic [9:0] bits;
        bits = {stopVal, data, 1'b0};
        if (abortBit < 0) begin
            expQ.push_back('{isErr: ~stopVal, data: data});
        end
        for (int b = 0; b < 10; b++) begin
            rxLine = bits[b];
            for (int c = 0; c < bitClk; c++) begin
                if (b == abortBit && c == 80) begin
                    doReset();
                    return;
                end
                if (b == spikeBit && c == 85) rxLine = ~bits[b];
                if (b == spikeBit && c == 86) rxLine = bits[b];
                @(negedge clk);
            end
        end
    endtask

    task automatic idleGap(input int n);
        rxLine = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops one expectation per strobe and checks RXD_DATA holds
    // the model's last good byte on every other cycle.
    always @(negedge clk) begin
        if (rstN) begin
            if (uartState && frameErr) begin
                checkOutput("strobe_exclusive", 32'h1, 32'h0);
            end
            if (uartState || frameErr) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", {30'h0, uartState, frameErr}, 32'h0);
                end else begin
                    monEv = expQ.pop_front();
                    checkOutput("event_kind", {31'h0, frameErr}, {31'h0, monEv.isErr});
                    if (!monEv.isErr) modelLast = monEv.data;
                    checkOutput(monEv.isErr ? "held_data" : "rx_data",
                                {24'h0, rxdData}, {24'h0, modelLast});
                end
            end else begin
                checkOutput("data_hold", {24'h0, rxdData}, {24'h0, modelLast});
            end
        end
    end

    initial begin
        logic [7:0] rndData;
        logic       rndBad;
        int         rndClk;

        repeat (3) @(negedge clk);
        doReset();

        // single frame
        applyStimulus(8'hB1, 1'b1, BIT_CLK, -1, -1);
        idleGap(20);

        // back-to-back, no idle gap
        applyStimulus(8'hB4, 1'b1, BIT_CLK, -1, -1);
        applyStimulus(8'h00, 1'b1, BIT_CLK, -1, -1);
        idleGap(20);

        // 40-clock glitch on an idle line
        rxLine = 1'b0;
        repeat (40) @(negedge clk);
        rxLine = 1'b1;
        repeat (150) @(negedge clk);
        checkOutput("glitch_not_busy", {31'h0, busy}, 32'h0);

        // 1-clock spike inside data bit 3 (frame bit 4)
        applyStimulus(8'hA2, 1'b1, BIT_CLK, 4, -1);
        idleGap(20);

        // framing error with the line held low afterwards
        applyStimulus(8'hA3, 1'b0, BIT_CLK, -1, -1);
        repeat (250) @(negedge clk);
        checkOutput("break_busy", {31'h0, busy}, 32'h1);
        repeat (250) @(negedge clk);
        checkOutput("break_still_busy", {31'h0, busy}, 32'h1);
        idleGap(6);
        checkOutput("break_released", {31'h0, busy}, 32'h0);
        applyStimulus(8'hA4, 1'b1, BIT_CLK, -1, -1);
        idleGap(20);

        // reset during data bit 4 (frame bit 5), then a clean frame
        applyStimulus(8'hB2, 1'b1, BIT_CLK, -1, 5);
        idleGap(20);
        applyStimulus(8'hB3, 1'b1, BIT_CLK, -1, -1);
        idleGap(20);

        // sender at +3% and -3% bit period
        applyStimulus(8'h55, 1'b1, 165, -1, -1);
        idleGap(20);
        applyStimulus(8'hAA, 1'b1, 165, -1, -1);
        idleGap(20);
        applyStimulus(8'h55, 1'b1, 155, -1, -1);
        idleGap(20);
        applyStimulus(8'hAA, 1'b1, 155, -1, -1);
        idleGap(20);

        // randomized frames, occasional bad stop bit, jittered baud and gaps
        for (int i = 0; i < 16; i++) begin
            rndData = 8'($urandom);
            rndBad  = ($urandom_range(0, 4) == 0);
            rndClk  = $urandom_range(155, 165);
            applyStimulus(rndData, ~rndBad, rndClk, -1, -1);
            if (rndBad) begin
                repeat ($urandom_range(0, 300)) @(negedge clk);
                idleGap(10 + $urandom_range(0, 30));
            end else begin
                idleGap($urandom_range(0, 40));
            end
        end

        // let any outstanding strobe arrive, bounded
        for (int i = 0; i < 3000 && expQ.size() > 0; i++) @(negedge clk);
        checkOutput("scoreboard_drain", expQ.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
